// File: rtl/stream_demux_router.sv
// Packet-aware 1:N stream demux with a single registered holding stage.
// The destination is locked on a packet's first beat; bad selects drop the whole packet.
//   state   | meaning
//   IDLE    | between packets, next accepted beat is a first beat
//   FWD     | mid-packet, beats follow the locked destination
//   DROP    | mid-packet with invalid select, beats consumed and discarded
module stream_demux_router #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 2,
    parameter int SEL_W  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_last,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_last,
    output logic                    drop_err,
    output logic [15:0]             pkt_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    localparam logic [SEL_W:0] N_OUT_W = (SEL_W + 1)'(N_OUT);

    logic [1:0]        state_q, state_d;
    logic              hold_v_q, hold_v_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              hold_last_q, hold_last_d;
    logic [SEL_W-1:0]  hold_dest_q, hold_dest_d;
    logic [SEL_W-1:0]  lock_dest_q, lock_dest_d;
    logic              drop_err_q, drop_err_d;
    logic [15:0]       pkt_count_q, pkt_count_d;

    logic [N_OUT-1:0]  dest_hit;
    logic              dest_ready;
    logic              pop;
    logic              accept;
    logic              sel_ok;

    always_comb begin
        dest_hit = '0;
        for (int i = 0; i < N_OUT; i++) begin
            dest_hit[i] = (hold_dest_q == SEL_W'(i));
        end
        dest_ready = |(out_ready & dest_hit);
        pop        = hold_v_q & dest_ready;
        sel_ok     = ({1'b0, in_sel} < N_OUT_W);
        in_ready   = !rst & ((state_q == ST_DROP) | !hold_v_q | dest_ready);
        accept     = in_valid & in_ready;
    end

    always_comb begin
        state_d     = state_q;
        hold_v_d    = hold_v_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        hold_dest_d = hold_dest_q;
        lock_dest_d = lock_dest_q;
        drop_err_d  = 1'b0;
        pkt_count_d = pkt_count_q;

        if (pop) begin
            hold_v_d = 1'b0;
            if (hold_last_q) begin
                pkt_count_d = pkt_count_q + 16'd1;
            end
        end

        // A push in the same cycle as a pop overrides the clear above.
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (sel_ok) begin
                        hold_v_d    = 1'b1;
                        hold_data_d = in_data;
                        hold_last_d = in_last;
                        hold_dest_d = in_sel;
                        lock_dest_d = in_sel;
                        if (!in_last) begin
                            state_d = ST_FWD;
                        end
                    end else if (in_last) begin
                        drop_err_d = 1'b1;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_FWD: begin
                if (accept) begin
                    hold_v_d    = 1'b1;
                    hold_data_d = in_data;
                    hold_last_d = in_last;
                    hold_dest_d = lock_dest_q;
                    if (in_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (accept && in_last) begin
                    state_d    = ST_IDLE;
                    drop_err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_v_q    <= 1'b0;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            hold_dest_q <= '0;
            lock_dest_q <= '0;
            drop_err_q  <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_v_q    <= hold_v_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            hold_dest_q <= hold_dest_d;
            lock_dest_q <= lock_dest_d;
            drop_err_q  <= drop_err_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // Unselected channels are forced to zero, not left holding stale data.
    always_comb begin
        out_valid = '0;
        out_last  = '0;
        out_data  = '0;
        for (int i = 0; i < N_OUT; i++) begin
            out_valid[i] = hold_v_q & dest_hit[i];
            out_last[i]  = hold_v_q & dest_hit[i] & hold_last_q;
            if (hold_v_q && dest_hit[i]) begin
                out_data[i*DATA_W +: DATA_W] = hold_data_q;
            end
        end
    end

    assign drop_err  = drop_err_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_stream_demux_router.sv
// Bench for stream_demux_router: directed vector table, hand sequences and
// random traffic against a packet-level reference model, on 2- and 3-channel builds.
module tb_stream_demux_router;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       t_rst, t_valid, t_last, cur;
    logic [7:0] t_data;
    logic [1:0] t_sel;
    logic [2:0] t_ready;

    logic        in_ready2, drop_err2;
    logic [1:0]  out_valid2, out_last2;
    logic [15:0] out_data2, pkt_count2;
    logic        in_ready3, drop_err3;
    logic [2:0]  out_valid3, out_last3;
    logic [23:0] out_data3;
    logic [15:0] pkt_count3;

    stream_demux_router #(.DATA_W(8), .N_OUT(2), .SEL_W(1)) dut2 (
        .clk(clk), .rst(t_rst), .in_valid(t_valid & ~cur), .in_ready(in_ready2),
        .in_data(t_data), .in_last(t_last), .in_sel(t_sel[0]),
        .out_valid(out_valid2), .out_ready(t_ready[1:0]), .out_data(out_data2),
        .out_last(out_last2), .drop_err(drop_err2), .pkt_count(pkt_count2));

    stream_demux_router #(.DATA_W(8), .N_OUT(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst(t_rst), .in_valid(t_valid & cur), .in_ready(in_ready3),
        .in_data(t_data), .in_last(t_last), .in_sel(t_sel),
        .out_valid(out_valid3), .out_ready(t_ready), .out_data(out_data3),
        .out_last(out_last3), .drop_err(drop_err3), .pkt_count(pkt_count3));

    logic        o_ir, o_de;
    logic [2:0]  o_ov, o_ol;
    logic [23:0] o_od;
    logic [15:0] o_cnt;
    assign o_ir  = cur ? in_ready3 : in_ready2;
    assign o_de  = cur ? drop_err3 : drop_err2;
    assign o_ov  = cur ? out_valid3 : {1'b0, out_valid2};
    assign o_ol  = cur ? out_last3 : {1'b0, out_last2};
    assign o_od  = cur ? out_data3 : {8'h00, out_data2};
    assign o_cnt = cur ? pkt_count3 : pkt_count2;

    // Reference model: packet-level view of the active DUT.
    bit         m_hv, m_hl, m_inpkt, m_drop, m_derr;
    logic [7:0] m_hd;
    int         m_hdest, m_lock;
    int         m_cnt [2];

    int n_chk;
    int n_fail;

    typedef struct {
        bit         rst;
        bit         c;
        bit         v;
        logic [7:0] d;
        bit         l;
        logic [1:0] s;
        logic [2:0] rdy;
        bit         e_ir;
        logic [2:0] e_ov;
        logic [23:0] e_od;
        logic [2:0] e_ol;
        bit         e_de;
    } vec_t;
    vec_t tbl [$];

    function automatic vec_t mk(bit r, bit c, bit v, logic [7:0] d, bit l, logic [1:0] s,
                                logic [2:0] rdy, bit ir, logic [2:0] ov, logic [23:0] od,
                                logic [2:0] ol, bit de);
        vec_t x;
        x.rst = r; x.c = c; x.v = v; x.d = d; x.l = l; x.s = s; x.rdy = rdy;
        x.e_ir = ir; x.e_ov = ov; x.e_od = od; x.e_ol = ol; x.e_de = de;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit v, input logic [7:0] d, input bit l,
                         input logic [1:0] s, input logic [2:0] rdy);
        t_rst = r; t_valid = v; t_data = d; t_last = l; t_sel = s; t_ready = rdy;
        #1;
    endtask

    task automatic load(input int dest);
        m_hv = 1'b1; m_hd = t_data; m_hl = t_last; m_hdest = dest;
    endtask

    // Check the active DUT against the model, advance the model, then one clock.
    task automatic cyc();
        int n;
        bit e_ir, pop, acc;
        n = cur ? 3 : 2;
        e_ir = !t_rst && (m_drop || !m_hv || t_ready[m_hdest]);
        chk("in_ready", 32'(o_ir), 32'(e_ir));
        chk("out_valid", 32'(o_ov), m_hv ? (32'd1 << m_hdest) : 32'd0);
        chk("out_data", 32'(o_od), m_hv ? (32'(m_hd) << (8 * m_hdest)) : 32'd0);
        chk("out_last", 32'(o_ol), (m_hv && m_hl) ? (32'd1 << m_hdest) : 32'd0);
        chk("drop_err", 32'(o_de), 32'(m_derr));
        chk("pkt_count", 32'(o_cnt), 32'(m_cnt[cur]));
        pop = m_hv && t_ready[m_hdest];
        acc = t_valid && e_ir;
        if (t_rst) begin
            m_hv = 0; m_hl = 0; m_hd = 0; m_hdest = 0; m_lock = 0;
            m_inpkt = 0; m_drop = 0; m_derr = 0; m_cnt[0] = 0; m_cnt[1] = 0;
        end else begin
            m_derr = 0;
            if (pop) begin
                m_hv = 0;
                if (m_hl) m_cnt[cur] = (m_cnt[cur] + 1) % 65536;
            end
            if (acc) begin
                if (m_drop) begin
                    if (t_last) begin m_drop = 0; m_derr = 1; end
                end else if (m_inpkt) begin
                    load(m_lock);
                    if (t_last) m_inpkt = 0;
                end else if (int'(t_sel) < n) begin
                    load(int'(t_sel));
                    if (!t_last) begin m_inpkt = 1; m_lock = int'(t_sel); end
                end else if (t_last) begin
                    m_derr = 1;
                end else begin
                    m_drop = 1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        m_hv = 0; m_hl = 0; m_hd = 0; m_hdest = 0; m_lock = 0;
        m_inpkt = 0; m_drop = 0; m_derr = 0; m_cnt[0] = 0; m_cnt[1] = 0;
        cur = 1'b0;
        t_rst = 1'b1; t_valid = 1'b0; t_data = '0; t_last = 1'b0; t_sel = '0; t_ready = 3'b011;
        @(posedge clk);
        @(negedge clk);

        //                rst   cur   v     data   last  sel    rdy     ir    ov      od          ol      de
        tbl.push_back(mk(1'b1,1'b0,1'b0,8'h00,1'b0,2'd0,3'b011,1'b0,3'b000,24'h000000,3'b000,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b0,2'd0,3'b011,1'b1,3'b000,24'h000000,3'b000,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b1,8'hA1,1'b0,2'd1,3'b011,1'b1,3'b000,24'h000000,3'b000,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b1,8'hA2,1'b0,2'd0,3'b011,1'b1,3'b010,24'h00A100,3'b000,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b1,8'hA3,1'b1,2'd0,3'b011,1'b1,3'b010,24'h00A200,3'b000,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b0,2'd0,3'b011,1'b1,3'b010,24'h00A300,3'b010,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b0,2'd0,3'b011,1'b1,3'b000,24'h000000,3'b000,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b1,8'h11,1'b0,2'd0,3'b011,1'b1,3'b000,24'h000000,3'b000,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b1,8'h22,1'b1,2'd1,3'b011,1'b1,3'b001,24'h000011,3'b000,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b0,2'd0,3'b011,1'b1,3'b001,24'h000022,3'b001,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b0,2'd0,3'b011,1'b1,3'b000,24'h000000,3'b000,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b1,8'hB1,1'b0,2'd0,3'b011,1'b1,3'b000,24'h000000,3'b000,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b1,8'hB2,1'b0,2'd0,3'b011,1'b1,3'b001,24'h0000B1,3'b000,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b1,8'hB3,1'b0,2'd1,3'b010,1'b0,3'b001,24'h0000B2,3'b000,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b1,8'hB3,1'b0,2'd1,3'b010,1'b0,3'b001,24'h0000B2,3'b000,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b1,8'hB3,1'b0,2'd1,3'b010,1'b0,3'b001,24'h0000B2,3'b000,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b1,8'hB3,1'b0,2'd0,3'b011,1'b1,3'b001,24'h0000B2,3'b000,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b1,8'hB4,1'b1,2'd0,3'b011,1'b1,3'b001,24'h0000B3,3'b000,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b0,2'd0,3'b011,1'b1,3'b001,24'h0000B4,3'b001,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,8'h00,1'b0,2'd0,3'b011,1'b1,3'b000,24'h000000,3'b000,1'b0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,8'h00,1'b0,2'd0,3'b111,1'b0,3'b000,24'h000000,3'b000,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,8'hC1,1'b0,2'd3,3'b111,1'b1,3'b000,24'h000000,3'b000,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,8'hC2,1'b1,2'd0,3'b111,1'b1,3'b000,24'h000000,3'b000,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,8'hD1,1'b0,2'd2,3'b111,1'b1,3'b000,24'h000000,3'b000,1'b1));
        tbl.push_back(mk(1'b0,1'b1,1'b1,8'hD2,1'b1,2'd0,3'b111,1'b1,3'b100,24'hD10000,3'b000,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,8'h00,1'b0,2'd0,3'b111,1'b1,3'b100,24'hD20000,3'b100,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,8'h00,1'b0,2'd0,3'b111,1'b1,3'b000,24'h000000,3'b000,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b1,8'hE0,1'b1,2'd3,3'b111,1'b1,3'b000,24'h000000,3'b000,1'b0));
        tbl.push_back(mk(1'b0,1'b1,1'b0,8'h00,1'b0,2'd0,3'b111,1'b1,3'b000,24'h000000,3'b000,1'b1));
        tbl.push_back(mk(1'b0,1'b1,1'b0,8'h00,1'b0,2'd0,3'b111,1'b1,3'b000,24'h000000,3'b000,1'b0));

        foreach (tbl[k]) begin
            cur = tbl[k].c;
            drive(tbl[k].rst, tbl[k].v, tbl[k].d, tbl[k].l, tbl[k].s, tbl[k].rdy);
            chk($sformatf("tbl%0d_in_ready", k), 32'(o_ir), 32'(tbl[k].e_ir));
            chk($sformatf("tbl%0d_out_valid", k), 32'(o_ov), 32'(tbl[k].e_ov));
            chk($sformatf("tbl%0d_out_data", k), 32'(o_od), 32'(tbl[k].e_od));
            chk($sformatf("tbl%0d_out_last", k), 32'(o_ol), 32'(tbl[k].e_ol));
            chk($sformatf("tbl%0d_drop_err", k), 32'(o_de), 32'(tbl[k].e_de));
            cyc();
        end

        // Random traffic on the 3-channel build, where select 3 is invalid.
        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
                  $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), 3'($urandom));
            cyc();
        end
        drive(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 3'b111);
        cyc();
        cur = 1'b0;

        // Reset while a beat is held mid-packet; the next packet must use its own select.
        drive(1'b0, 1'b1, 8'hE1, 1'b0, 2'd1, 3'b011);
        cyc();
        drive(1'b0, 1'b1, 8'hE2, 1'b0, 2'd0, 3'b000);
        chk("t6_held_valid", 32'(o_ov), 32'h2);
        chk("t6_backpressure_ready", 32'(o_ir), 32'h0);
        cyc();
        drive(1'b1, 1'b1, 8'hE2, 1'b0, 2'd0, 3'b000);
        chk("t6_rst_ready", 32'(o_ir), 32'h0);
        cyc();
        drive(1'b0, 1'b1, 8'hF1, 1'b1, 2'd0, 3'b011);
        chk("t6_cleared_valid", 32'(o_ov), 32'h0);
        chk("t6_cleared_count", 32'(o_cnt), 32'h0);
        cyc();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 3'b011);
        chk("t6_fresh_sel_valid", 32'(o_ov), 32'h1);
        chk("t6_fresh_sel_data", 32'(o_od), 32'hF1);
        cyc();

        // Back-to-back single-beat packets up to the counter wrap.
        for (int k = 0; k < 65534; k++) begin
            drive(1'b0, 1'b1, 8'($urandom), 1'b1, 2'($urandom_range(0, 1)), 3'b011);
            cyc();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 3'b011);
        cyc();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 3'b011);
        chk("wrap_ffff", 32'(o_cnt), 32'hFFFF);
        cyc();
        drive(1'b0, 1'b1, 8'h5A, 1'b1, 2'd0, 3'b011);
        cyc();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 3'b011);
        cyc();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 3'b011);
        chk("wrap_zero", 32'(o_cnt), 32'h0);
        cyc();

        // Random traffic on the 2-channel build (every select is valid).
        for (int k = 0; k < 1000; k++) begin
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
                  $urandom_range(0, 2) == 0, 2'($urandom_range(0, 1)), {1'b0, 2'($urandom)});
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
